// File: rtl/shift_rx.sv
// shift_rx: oversampling serial receiver for an FTDI-style 8N1 line.
//
// The line is first synchronized into the baud_clk domain. A falling edge
// starts a frame. The start bit is confirmed at mid-bit. Each data bit is then
// sampled one full bit period later, LSB first, and finally the stop bit is
// checked.
//
// Optional feature: define SHIFT_RX_MAJORITY_EN to make every start, data and
// stop decision a 2-of-3 vote. The vote covers the synchronized line in the
// decision cycle and the two cycles before it. Without the macro, each decision
// uses the single synchronized sample, and the history register is not built.
//
// Parameters:
//   DATA_WIDTH - data bits per frame (>= 2)
//   OVERSAMPLE - baud_clk cycles per bit (even, >= 4)
// Ports:
//   baud_clk   - clock, OVERSAMPLE x baud rate
//   reset      - synchronous active-high reset
//   ftdi_rx    - asynchronous serial input, idles high
//   data_byte  - last good received word
//   data_valid - one-cycle pulse when data_byte updates
//   frame_err  - one-cycle pulse when a stop bit was sampled low
//   busy       - high while a frame (or a break) is in progress
module shift_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  baud_clk,
  input  logic                  reset,
  input  logic                  ftdi_rx,
  output logic [DATA_WIDTH-1:0] data_byte,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [IW-1:0]         idx, idx_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic                  rx_meta, rx_s;
  logic                  rx_bit;
  logic                  load, ferr;

  // Two-flop synchronizer. It resets to the idle-high level, so no false
  // start bit appears out of reset.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= ftdi_rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef SHIFT_RX_MAJORITY_EN
  logic [2:0] rx_hist;

  // rx_hist[0] loads from rx_meta on the same edge as rx_s, so it always
  // equals rx_s. rx_hist[2:1] hold the two previous rx_s values.
  always_ff @(posedge baud_clk) begin
    if (reset) rx_hist <= 3'b111;
    else       rx_hist <= {rx_hist[1:0], rx_meta};
  end

  assign rx_bit = (rx_hist[0] & rx_hist[1]) | (rx_hist[0] & rx_hist[2]) |
                  (rx_hist[1] & rx_hist[2]);
`else
  assign rx_bit = rx_s;
`endif

  // Next-state, counter and shift-register logic.
  // A frame ends with a stop-bit verdict:
  //   load - a good word is captured
  //   ferr - a framing error is flagged
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    idx_next   = idx;
    shreg_next = shreg;
    load       = 1'b0;
    ferr       = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_next   = '0;
          shreg_next = {rx_bit, shreg[DATA_WIDTH-1:1]};
          idx_next   = idx + IW'(1);
          if (idx == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_next = '0;
          if (rx_bit) begin
            load       = 1'b1;
            state_next = IDLE;
          end else begin
            ferr       = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and output registers. The result pulses appear in the
  // cycle after the stop-bit decision.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_byte  <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      shreg      <= shreg_next;
      data_valid <= load;
      frame_err  <= ferr;
      if (load) data_byte <= shreg;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_rx.sv
// tb_shift_rx: directed bench for shift_rx (DATA_WIDTH=8, OVERSAMPLE=16).
// Drives hand-built serial frames and compares the outputs against
// hand-computed values. Works with or without SHIFT_RX_MAJORITY_EN.
module tb_shift_rx;
  localparam int DW = 8;
  localparam int OS = 16;

  logic          baud_clk = 1'b0;
  logic          reset;
  logic          ftdi_rx;
  logic [DW-1:0] data_byte;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  int checks = 0;
  int passes = 0;
  int cycle_cnt = 0;
  int dv_count = 0;
  int fe_count = 0;
  int overlap = 0;
  int dv_cycle = 0;
  int dv_cycle_prev = 0;
  int frame_start = 0;
  logic [DW-1:0] dv_data = '0;

  always #5 baud_clk = ~baud_clk;

  shift_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .baud_clk  (baud_clk),
    .reset     (reset),
    .ftdi_rx   (ftdi_rx),
    .data_byte (data_byte),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Free-running cycle count, used to timestamp the result pulses.
  always @(posedge baud_clk) cycle_cnt <= cycle_cnt + 1;

  // Pulse monitor, sampled on the falling edge, away from the active edge.
  always @(negedge baud_clk) begin
    if (data_valid) begin
      dv_count++;
      dv_cycle_prev = dv_cycle;
      dv_cycle      = cycle_cnt;
      dv_data       = data_byte;
    end
    if (frame_err) fe_count++;
    if (data_valid && frame_err) overlap++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Hold the line at v for n bit-cycles.
  // Each call starts and ends 1 time unit after a rising edge.
  task automatic hold_line(input logic v, input int n);
    repeat (n) begin
      ftdi_rx = v;
      @(posedge baud_clk);
      #1;
    end
  endtask

  // Send one frame: start bit, data LSB first, then the given stop-bit level.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic stop_v);
    frame_start = cycle_cnt;
    hold_line(1'b0, OS);
    for (int i = 0; i < DW; i++) hold_line(d[i], OS);
    hold_line(stop_v, OS);
  endtask

  int dv0, fe0, lat, k;

  initial begin
    reset   = 1'b1;
    ftdi_rx = 1'b1;
    repeat (4) @(posedge baud_clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_data_byte", 32'(data_byte), 32'h0);
    checkOutput("rst_data_valid", 32'(data_valid), 32'h0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    hold_line(1'b1, 20);
    checkOutput("idle_busy", 32'(busy), 32'h0);

    $display("[TB] single frame 0x47");
    dv0 = dv_count; fe0 = fe_count;
    applyStimulus(8'h47, 1'b1);
    hold_line(1'b1, 4);
    lat = dv_cycle - frame_start;
    checkOutput("t47_dv_count", 32'(dv_count - dv0), 32'd1);
    checkOutput("t47_dv_data", 32'(dv_data), 32'h47);
    checkOutput("t47_data_byte", 32'(data_byte), 32'h47);
    checkOutput("t47_latency_152_156", 32'((lat >= 152 && lat <= 156) ? 1 : 0), 32'd1);
    checkOutput("t47_no_frame_err", 32'(fe_count - fe0), 32'd0);

    $display("[TB] back-to-back 0x55 0xAA");
    dv0 = dv_count;
    applyStimulus(8'h55, 1'b1);
    checkOutput("b2b_first_data", 32'(dv_data), 32'h55);
    applyStimulus(8'hAA, 1'b1);
    checkOutput("b2b_second_data", 32'(dv_data), 32'hAA);
    checkOutput("b2b_dv_count", 32'(dv_count - dv0), 32'd2);
    checkOutput("b2b_spacing", 32'(dv_cycle - dv_cycle_prev), 32'd160);
    hold_line(1'b1, 20);

    $display("[TB] 4-cycle start glitch");
    dv0 = dv_count; fe0 = fe_count;
    hold_line(1'b0, 4);
    checkOutput("glitch_busy_rose", 32'(busy), 32'h1);
    hold_line(1'b1, 8);
    checkOutput("glitch_busy_fell", 32'(busy), 32'h0);
    hold_line(1'b1, 10);
    checkOutput("glitch_no_dv", 32'(dv_count - dv0), 32'd0);
    checkOutput("glitch_no_fe", 32'(fe_count - fe0), 32'd0);

    $display("[TB] framing error on 0x3C");
    dv0 = dv_count; fe0 = fe_count;
    applyStimulus(8'h3C, 1'b0);
    hold_line(1'b0, 40);
    checkOutput("ferr_count", 32'(fe_count - fe0), 32'd1);
    checkOutput("ferr_no_dv", 32'(dv_count - dv0), 32'd0);
    checkOutput("ferr_data_kept", 32'(data_byte), 32'hAA);
    checkOutput("ferr_busy_in_break", 32'(busy), 32'h1);
    ftdi_rx = 1'b1;
    k = 0;
    while (busy && k < 10) begin
      @(posedge baud_clk);
      #1;
      k++;
    end
    checkOutput("ferr_busy_release_2_3", 32'((k >= 2 && k <= 3) ? 1 : 0), 32'd1);
    hold_line(1'b1, 10);

    $display("[TB] reset during bit 4 of 0xF0");
    dv0 = dv_count; fe0 = fe_count;
    hold_line(1'b0, OS * 5);
    ftdi_rx = 1'b1;
    reset   = 1'b1;
    @(posedge baud_clk);
    #1;
    reset = 1'b0;
    checkOutput("midrst_data_byte", 32'(data_byte), 32'h0);
    checkOutput("midrst_data_valid", 32'(data_valid), 32'h0);
    checkOutput("midrst_frame_err", 32'(frame_err), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    hold_line(1'b1, OS - 1 + OS * 3 + OS + 10);
    checkOutput("midrst_no_dv", 32'(dv_count - dv0), 32'd0);
    checkOutput("midrst_no_fe", 32'(fe_count - fe0), 32'd0);
    checkOutput("midrst_still_idle", 32'(busy), 32'h0);
    applyStimulus(8'h81, 1'b1);
    hold_line(1'b1, 4);
    checkOutput("midrst_next_dv", 32'(dv_count - dv0), 32'd1);
    checkOutput("midrst_next_data", 32'(data_byte), 32'h81);

    $display("[TB] one-cycle spike at centre of bit 2 of 0x00");
    hold_line(1'b0, OS * 3 + 8);
    hold_line(1'b1, 1);
    hold_line(1'b0, 7 + OS * 5);
    hold_line(1'b1, OS + 4);
`ifdef SHIFT_RX_MAJORITY_EN
    checkOutput("spike_data", 32'(data_byte), 32'h00);
`else
    checkOutput("spike_data", 32'(data_byte), 32'h04);
`endif

    checkOutput("never_dv_and_fe", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/shift_rx.md
SHIFT_RX -- requirements
Module: shift_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning baud_clk cycles per bit; it must be even and at least 4.
REQ-003 The block SHALL have port baud_clk, input, 1 bit: the single clock, running at OVERSAMPLE x the baud rate.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ftdi_rx, input, 1 bit: asynchronous serial line that idles high.
REQ-006 The block SHALL have port data_byte, output, DATA_WIDTH bits: last good received word, LSB received first.
REQ-007 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_byte updates.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 ftdi_rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rx_s).
REQ-011 The FSM SHALL have exactly these states: IDLE, START, DATA, STOP, BREAK.
REQ-012 In IDLE, rx_s==0 SHALL move the FSM to START and clear the sample counter.
REQ-013 In START, at counter==OVERSAMPLE/2-1, the FSM SHALL sample: 0 moves to DATA (counter and bit index cleared); 1 is a glitch and returns to IDLE with no output pulse.
REQ-014 In DATA, at each counter==OVERSAMPLE-1, the sampled bit SHALL be shifted in at the MSB (shift right).
REQ-015 In DATA, the counter SHALL wrap to 0 after each sample; after DATA_WIDTH samples the FSM SHALL move to STOP.
REQ-016 In STOP, at counter==OVERSAMPLE-1, a sampled 1 SHALL load data_byte from the shift register, pulse data_valid in the next cycle, and return to IDLE.
REQ-017 In STOP, a sampled 0 SHALL pulse frame_err in the next cycle, leave data_byte unchanged, and move to BREAK.
REQ-018 BREAK SHALL hold until rx_s==1, then move to IDLE.
REQ-019 data_valid and frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-020 Back-to-back frames SHALL be accepted: a falling edge seen in the first IDLE cycle after STOP starts a new frame with no lost cycles.
REQ-021 Counter width SHALL be $clog2(OVERSAMPLE); bit index width SHALL be $clog2(DATA_WIDTH+1). Neither SHALL overflow.

Reset
REQ-022 While reset is high on a baud_clk edge: FSM = IDLE, counters = 0, shift register = 0.
REQ-023 While reset is high on a baud_clk edge: data_byte = 0, data_valid = 0, frame_err = 0, busy = 0.
REQ-024 While reset is high on a baud_clk edge: both synchronizer flops = 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no data_valid or frame_err pulse.
REQ-026 After reset deasserts, reception SHALL resume only on a fresh falling edge.

Configuration
REQ-027 With macro SHIFT_RX_MAJORITY_EN defined, every bit decision (start, data, stop) SHALL use a 2-of-3 majority of rx_s over the decision cycle and the two preceding cycles; a 3-bit history register SHALL be reset to 3'b111.
REQ-028 Without SHIFT_RX_MAJORITY_EN, each bit decision SHALL use the single rx_s value in the decision cycle, and no history register SHALL exist.

Verification (DATA_WIDTH=8, OVERSAMPLE=16)
REQ-029 Send 0x47, 8N1 at 16 cycles/bit -> data_byte=0x47; data_valid pulses once, 154 +/-2 cycles after the ftdi_rx falling edge; frame_err stays 0.
REQ-030 Send 0x55 then 0xAA back-to-back with no idle gap -> two data_valid pulses, 160 cycles apart, with values 0x55 then 0xAA.
REQ-031 Drive a 4-cycle low glitch on an idle line -> FSM returns to IDLE; busy falls within 12 cycles; no data_valid, no frame_err.
REQ-032 Send 0x3C with the stop bit forced low, line held low for 40 more cycles, then high -> one frame_err pulse; data_byte keeps its previous value; busy stays high until 2-3 cycles after the line goes high.
REQ-033 Assert reset for 1 cycle during data bit 4 of 0xF0 -> no pulses; all outputs 0; the next 0x81 frame is received correctly.
REQ-034 With SHIFT_RX_MAJORITY_EN, invert ftdi_rx for 1 cycle at the center of bit 2 of 0x00 -> data_byte=0x00. Without the macro, the same stimulus -> 0x04.
